// File: rtl/redux_pkg.sv
// Shared definitions for the REDUX-V front end.
package redux_pkg;

    // Width of PC and instruction word; must match instruction_memory.
    localparam int MEMORY_BITS_DEFAULT = 8;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry ordered buffer: the output register seen by the decoder plus one
// skid entry that absorbs a response arriving while the output is stalled.
module fetch_skid_buffer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_push_instr,
    input  logic [W-1:0] i_push_pc,
    input  logic         i_pop,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_instr,
    output logic [W-1:0] o_out_pc,
    output logic [1:0]   o_occ
);

    logic         r_out_valid;
    logic [W-1:0] r_out_instr;
    logic [W-1:0] r_out_pc;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_instr;
    logic [W-1:0] r_skid_pc;

    logic         w_pop;
    logic         w_base_out_valid;
    logic [W-1:0] w_base_out_instr;
    logic [W-1:0] w_base_out_pc;
    logic         w_base_skid_valid;

    assign w_pop = i_pop && r_out_valid;

    // Contents after this cycle's pop, before any push is appended.
    always_comb begin
        w_base_out_valid  = r_out_valid;
        w_base_out_instr  = r_out_instr;
        w_base_out_pc     = r_out_pc;
        w_base_skid_valid = r_skid_valid;
        if (w_pop) begin
            w_base_out_valid  = r_skid_valid;
            w_base_skid_valid = 1'b0;
            if (r_skid_valid) begin
                w_base_out_instr = r_skid_instr;
                w_base_out_pc    = r_skid_pc;
            end
        end
    end

    // Entry registers: pop shifts skid forward, push fills the first free slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_out_valid  <= w_base_out_valid;
            r_out_instr  <= w_base_out_instr;
            r_out_pc     <= w_base_out_pc;
            r_skid_valid <= w_base_skid_valid;
            if (i_push) begin
                // The issue rule upstream must never let a third word arrive.
                assert (!(w_base_out_valid && w_base_skid_valid));
                if (!w_base_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_instr <= i_push_instr;
                    r_out_pc    <= i_push_pc;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_instr <= i_push_instr;
                    r_skid_pc    <= i_push_pc;
                end
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_instr = r_out_instr;
    assign o_out_pc    = r_out_pc;
    assign o_occ       = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read per cycle to the
// synchronous instruction memory and hands words to the decoder over
// valid/ready, with redirect, halt and back-pressure handling.
//
//   state  | meaning
//   RUN    | fetches issued whenever buffer space is guaranteed
//   HALTED | no new fetches; buffered words still drain
module fetch_unit
    import redux_pkg::*;
#(
    parameter int                     MEMORY_BITS = MEMORY_BITS_DEFAULT,
    parameter logic [MEMORY_BITS-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [MEMORY_BITS-1:0] pc,
    input  logic [MEMORY_BITS-1:0] instruction,
    input  logic                   redirect_valid,
    input  logic [MEMORY_BITS-1:0] redirect_pc,
    input  logic                   halt,
    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [MEMORY_BITS-1:0] fetch_instruction,
    output logic [MEMORY_BITS-1:0] fetch_pc,
    output logic                   halted
);

    fetch_state_t           r_state;
    fetch_state_t           w_state_next;
    logic [MEMORY_BITS-1:0] r_pc;
    logic                   r_inflight;
    logic [MEMORY_BITS-1:0] r_inflight_pc;

    logic                   w_pop;
    logic                   w_push;
    logic                   w_issue;
    logic [1:0]             w_buf_occ;
    logic [2:0]             w_occ;

    // A word being consumed this cycle frees its slot for a new issue.
    assign w_pop  = fetch_valid && fetch_ready;
    assign w_occ  = {1'b0, w_buf_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == RUN) && !redirect_valid && (w_occ < 3'd2);
    // The response for a fetch issued before a redirect is dropped here.
    assign w_push = r_inflight && !redirect_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: halt wins over a simultaneous redirect.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (halt) w_state_next = HALTED;
            HALTED:  if (redirect_valid && !halt) w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // PC and in-flight tracking for the one outstanding memory read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_skid_buffer #(
        .W (MEMORY_BITS)
    ) u_buf (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_instr (instruction),
        .i_push_pc    (r_inflight_pc),
        .i_pop        (w_pop),
        .o_out_valid  (fetch_valid),
        .o_out_instr  (fetch_instruction),
        .o_out_pc     (fetch_pc),
        .o_occ        (w_buf_occ)
    );

    assign pc     = r_pc;
    assign halted = (r_state == HALTED);

endmodule
